inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Instruction fetch stage that sits directly upstream of the systolic-array control unit.
- Host (AXI-lite slave registers) pushes 16-bit instructions into an internal FIFO, then pulses start.
- The block presents the head instruction to the control unit and pops it each time the control unit asserts flag (instruction accepted).
- Outputs the idle instruction (16'h0000) when not running or empty; reports completion, occupancy and overflow to the host.

Parameters:
- INST_BITS, 16, instruction width (opcode in upper bits; opcode 0 = IDLE_INST, so 16'h0000 is idle).
- DEPTH, 64, FIFO entries (power of 2).
- PTR_BITS, 6, log2(DEPTH).

Ports:
- clk  in  1  clock, all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  host push strobe, one instruction per cycle.
- wr_data  in  INST_BITS  instruction to push.
- start  in  1  pulse; begin issuing from IDLE.
- clear  in  1  synchronous flush of FIFO, state and sticky flags.
- flag  in  1  from control unit; high = current instruction accepted at this edge.
- instruction  out  INST_BITS  to control unit.
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse at program end.
- overflow  out  1  sticky; push attempted while full.
- count  out  PTR_BITS+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async): state=IDLE, rd_ptr=wr_ptr=0, count=0, overflow=0, done=0, busy=0. instruction=0 (combinational from state).
- Storage: DEPTH x INST_BITS array, asynchronous read at rd_ptr. Pointers wrap modulo DEPTH. count is a registered occupancy counter.
- instruction = mem[rd_ptr] when state==RUN and count!=0, else 16'h0000. Combinational, so it is valid at the same edge where the control unit samples it with flag=1.
- States: IDLE, RUN.
  - IDLE -> RUN: start=1 and count!=0.
  - start with count==0: ignored, no done pulse.
  - start while in RUN: ignored.
  - RUN, flag=1, count!=0: pop (rd_ptr+1, count-1).
  - RUN, flag=1, count==0: last instruction completed. done=1 for one cycle; state -> IDLE.
  - RUN, flag=0: hold. instruction remains stable for multi-cycle instructions (AXI_TO_UB, ACC_TO_UB wait states).
- Push:
  - wr_en=1 and count<DEPTH: write mem[wr_ptr], wr_ptr+1, count+1.
  - wr_en=1 and count==DEPTH: data dropped, overflow set (sticky until clear/reset).
- Simultaneous push and pop: both occur, count unchanged. A push while full in the same cycle as a pop is still dropped: fullness is judged on the registered count.
- Empty decision uses the registered count. A push arriving in the same cycle as the terminating flag edge is stored but does not prevent done; it stays queued for the next start.
- Pushes are accepted in both IDLE and RUN (streaming refill allowed).
- clear: highest priority over push, pop and start. Pointers and count go to 0, state -> IDLE, overflow -> 0, done -> 0. Memory contents are don't-care.
- Reset mid-RUN: immediate return to reset values; instruction drops to 0 asynchronously.
- Latency: push to visible at instruction is 1 cycle. Pop to next head is visible right after the edge.

Optional Feature:
- Macro INST_QUEUE_PERF_CNT_EN.
- Defined: adds output issued_cnt [31:0]. It increments on every pop, clears on reset, clear, and IDLE->RUN, and holds after done. Also adds stall_cnt [31:0], which increments each RUN cycle with flag=0 and has the same clear rules.
- Undefined: neither port nor counter exists; no other behaviour changes.

Test Plan:
- Push 16'h1234, 16'h2345, 16'h3456; start; flag=1 every cycle -> instruction shows 1234, 2345, 3456 on successive cycles, then 0000. done pulses on the 4th flag edge; busy high for 4 cycles; count goes 3,2,1,0.
- Push 2 instructions; start; hold flag=0 for 5 cycles -> instruction holds the first value and count stays 2. Then flag=1 -> advances to the second.
- Push 65 instructions with DEPTH=64 -> count=64, overflow=1. The 65th value is never issued; overflow clears only on clear.
- In RUN with count=1, assert wr_en and flag in the same cycle -> count stays 1 and the new instruction becomes the head, with no done. Separately, pushing on the terminating edge -> done=1, state IDLE, count=1.
- start with an empty FIFO -> busy stays 0, no done, instruction=0000. Then clear mid-RUN with 10 queued -> count=0, busy=0, instruction=0000 next cycle.
- Assert reset_n low mid-RUN between clock edges -> instruction=0000 and busy=0 immediately. With INST_QUEUE_PERF_CNT_EN defined, issued_cnt=0.

Source files
------------

// File: rtl/inst_queue_if.sv
// Instruction queue bus: host push strobe/data and control-unit issue/accept handshake.
// The queue is the slave; the side that pushes and accepts instructions is the master.
interface inst_queue_if #(
   parameter int INST_BITS = 16
);
   logic                 wr_en;
   logic [INST_BITS-1:0] wr_data;
   logic                 flag;
   logic [INST_BITS-1:0] instruction;

   modport master (output wr_en, output wr_data, output flag, input instruction);
   modport slave  (input wr_en, input wr_data, input flag, output instruction);
endinterface

// File: rtl/inst_queue.sv
// Instruction fetch FIFO feeding the systolic-array control unit; pops on flag while running.
// Optional INST_QUEUE_PERF_CNT_EN adds issued_cnt/stall_cnt performance counters.
module inst_queue #(
   parameter int INST_BITS = 16,
   parameter int DEPTH     = 64,
   parameter int PTR_BITS  = 6
) (
   input  logic                clk,
   input  logic                reset_n,
   inst_queue_if.slave         bus,
   input  logic                start,
   input  logic                clear,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [PTR_BITS:0]   count
`ifdef INST_QUEUE_PERF_CNT_EN
   ,
   output logic [31:0]         issued_cnt,
   output logic [31:0]         stall_cnt
`endif
);

   localparam int CNT_W = PTR_BITS + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_e;

   state_e                state_q, state_d;
   logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  done_q, done_d;

   logic [INST_BITS-1:0]  mem [DEPTH];

   logic running, empty, full, push_ok, pop, finish, launch;

   // Empty/full decisions use the registered count, so same-edge pushes never rescue a pop or a finish.
   assign running = (state_q == S_RUN);
   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign push_ok = bus.wr_en && !full && !clear;
   assign pop     = running && bus.flag && !empty && !clear;
   assign finish  = running && bus.flag && empty && !clear;
   assign launch  = !running && start && !empty && !clear;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
      overflow_d = overflow_q || (bus.wr_en && full);
      done_d     = finish;

      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
      if (launch)  state_d  = S_RUN;
      if (finish)  state_d  = S_IDLE;

      if (clear) begin
         state_d    = S_IDLE;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         done_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (!reset_n) begin
         state_q    <= S_IDLE;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= bus.wr_data;
   end

   assign bus.instruction = (running && !empty) ? mem[rd_ptr_q] : '0;
   assign busy            = running;
   assign done            = done_q;
   assign overflow        = overflow_q;
   assign count           = count_q;

`ifdef INST_QUEUE_PERF_CNT_EN
   logic [31:0] issued_q, issued_d;
   logic [31:0] stall_q, stall_d;

   always_comb begin
      issued_d = issued_q;
      stall_d  = stall_q;
      if (clear || launch) begin
         issued_d = '0;
         stall_d  = '0;
      end else begin
         if (pop)                     issued_d = issued_q + 32'd1;
         if (running && !bus.flag)    stall_d  = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         issued_q <= '0;
         stall_q  <= '0;
      end else begin
         issued_q <= issued_d;
         stall_q  <= stall_d;
      end
   end

   assign issued_cnt = issued_q;
   assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed vector table plus hand sequences for
// overflow, clear, push-on-pop while full and asynchronous reset mid-run.
module tb_inst_queue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, clear;
   logic        busy, done, overflow;
   logic [6:0]  count;
`ifdef INST_QUEUE_PERF_CNT_EN
   logic [31:0] issued_cnt, stall_cnt;
`endif

   int errors = 0;
   int checks = 0;

   inst_queue_if #(.INST_BITS(16)) bus ();

   inst_queue dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .start      (start),
      .clear      (clear),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .count      (count)
`ifdef INST_QUEUE_PERF_CNT_EN
      ,
      .issued_cnt (issued_cnt),
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [15:0] data;
      logic        st;
      logic        clr;
      logic        flg;
      logic [15:0] e_inst;
      logic        e_busy;
      logic        e_done;
      logic [6:0]  e_count;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic wr, input logic [15:0] data, input logic st, input logic clr,
                      input logic flg, input logic [15:0] e_inst, input logic e_busy,
                      input logic e_done, input logic [6:0] e_count);
      vec_t v;
      v.wr = wr; v.data = data; v.st = st; v.clr = clr; v.flg = flg;
      v.e_inst = e_inst; v.e_busy = e_busy; v.e_done = e_done; v.e_count = e_count;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic wr, input logic [15:0] data, input logic st,
                        input logic clr, input logic flg);
      bus.wr_en = wr; bus.wr_data = data; start = st; clear = clr; bus.flag = flg;
   endtask

   // Advance one clock and sample 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      drive(0, 16'h0, 0, 0, 0);

      //   wr  data      st clr flg  inst      busy done count
      // Three-instruction program, flag every cycle.
      add(1, 16'h1234, 0, 0, 0, 16'h0000, 0, 0, 7'd1);
      add(1, 16'h2345, 0, 0, 0, 16'h0000, 0, 0, 7'd2);
      add(1, 16'h3456, 0, 0, 0, 16'h0000, 0, 0, 7'd3);
      add(0, 16'h0000, 1, 0, 0, 16'h1234, 1, 0, 7'd3);
      add(0, 16'h0000, 0, 0, 1, 16'h2345, 1, 0, 7'd2);
      add(0, 16'h0000, 0, 0, 1, 16'h3456, 1, 0, 7'd1);
      add(0, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 7'd0);
      add(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 7'd0);
      add(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 7'd0);
      // Multi-cycle hold with flag low.
      add(1, 16'hAAAA, 0, 0, 0, 16'h0000, 0, 0, 7'd1);
      add(1, 16'hBBBB, 0, 0, 0, 16'h0000, 0, 0, 7'd2);
      add(0, 16'h0000, 1, 0, 0, 16'hAAAA, 1, 0, 7'd2);
      for (int i = 0; i < 5; i++)
         add(0, 16'h0000, 0, 0, 0, 16'hAAAA, 1, 0, 7'd2);
      add(0, 16'h0000, 1, 0, 1, 16'hBBBB, 1, 0, 7'd1);
      add(0, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 7'd0);
      add(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 7'd0);
      // Push and pop together at count=1, then push on the terminating edge.
      add(1, 16'h1111, 0, 0, 0, 16'h0000, 0, 0, 7'd1);
      add(0, 16'h0000, 1, 0, 0, 16'h1111, 1, 0, 7'd1);
      add(1, 16'h2222, 0, 0, 1, 16'h2222, 1, 0, 7'd1);
      add(1, 16'h3333, 0, 0, 1, 16'h3333, 1, 0, 7'd1);
      add(0, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 7'd0);
      add(1, 16'h4444, 0, 0, 1, 16'h0000, 0, 1, 7'd1);
      add(0, 16'h0000, 1, 0, 0, 16'h4444, 1, 0, 7'd1);
      add(0, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 7'd0);
      add(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 7'd0);
      // Start on empty FIFO is ignored.
      add(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 7'd0);
      add(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 7'd0);
      // Clear beats push and start in the same cycle.
      add(1, 16'h5555, 0, 0, 0, 16'h0000, 0, 0, 7'd1);
      add(1, 16'h6666, 1, 1, 0, 16'h0000, 0, 0, 7'd0);

      #12;
      check("reset instruction", 32'(bus.instruction), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      check("reset done", 32'(done), 32'h0);
      check("reset count", 32'(count), 32'h0);
      check("reset overflow", 32'(overflow), 32'h0);
`ifdef INST_QUEUE_PERF_CNT_EN
      check("reset issued_cnt", issued_cnt, 32'h0);
      check("reset stall_cnt", stall_cnt, 32'h0);
`endif
      reset_n = 1'b1;
      step();

      foreach (vecs[i]) begin
         drive(vecs[i].wr, vecs[i].data, vecs[i].st, vecs[i].clr, vecs[i].flg);
         step();
         check($sformatf("v%0d instruction", i), 32'(bus.instruction), 32'(vecs[i].e_inst));
         check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
         check($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].e_done));
         check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_count));
         check($sformatf("v%0d overflow", i), 32'(overflow), 32'h0);
      end
      drive(0, 16'h0, 0, 0, 0);
      step();

      // 65 pushes into a 64-deep queue: the last one is dropped and overflow sticks.
      for (int i = 0; i < 65; i++) begin
         drive(1, 16'h0100 + 16'(i), 0, 0, 0);
         step();
      end
      drive(0, 16'h0, 0, 0, 0);
      check("fill count", 32'(count), 32'd64);
      check("fill overflow", 32'(overflow), 32'h1);
      drive(0, 16'h0, 1, 0, 0);
      step();
      for (int i = 0; i < 64; i++) begin
         check($sformatf("drain head %0d", i), 32'(bus.instruction), 32'h0100 + 32'(i));
         drive(0, 16'h0, 0, 0, 1);
         step();
      end
      check("drain extra instruction", 32'(bus.instruction), 32'h0);
      check("drain count", 32'(count), 32'h0);
      step();
      check("drain done", 32'(done), 32'h1);
      check("overflow sticky after run", 32'(overflow), 32'h1);
      drive(0, 16'h0, 0, 1, 0);
      step();
      check("clear overflow", 32'(overflow), 32'h0);

      // Push while full on a pop edge is still dropped.
      for (int i = 0; i < 64; i++) begin
         drive(1, 16'h0200 + 16'(i), 0, 0, 0);
         step();
      end
      check("refill overflow", 32'(overflow), 32'h0);
      drive(0, 16'h0, 1, 0, 0);
      step();
      check("full run head", 32'(bus.instruction), 32'h0200);
      drive(1, 16'hDEAD, 0, 0, 1);
      step();
      check("full pop+push count", 32'(count), 32'd63);
      check("full pop+push overflow", 32'(overflow), 32'h1);
      check("full pop+push head", 32'(bus.instruction), 32'h0201);
      drive(0, 16'h0, 0, 1, 0);
      step();

      // Clear mid-run with 10 queued; perf counters observed on the way.
      for (int i = 0; i < 10; i++) begin
         drive(1, 16'h0300 + 16'(i), 0, 0, 0);
         step();
      end
      drive(0, 16'h0, 1, 0, 0);
      step();
      drive(0, 16'h0, 0, 0, 0);
      step();
      step();
      drive(0, 16'h0, 0, 0, 1);
      step();
      step();
      check("mid-run head", 32'(bus.instruction), 32'h0302);
      check("mid-run count", 32'(count), 32'd8);
`ifdef INST_QUEUE_PERF_CNT_EN
      check("issued_cnt", issued_cnt, 32'd2);
      check("stall_cnt", stall_cnt, 32'd2);
`endif
      drive(0, 16'h0, 0, 1, 0);
      step();
      check("clear count", 32'(count), 32'h0);
      check("clear busy", 32'(busy), 32'h0);
      check("clear instruction", 32'(bus.instruction), 32'h0);
`ifdef INST_QUEUE_PERF_CNT_EN
      check("clear issued_cnt", issued_cnt, 32'h0);
`endif
      drive(0, 16'h0, 0, 0, 0);

      // Asynchronous reset between edges during RUN.
      for (int i = 0; i < 3; i++) begin
         drive(1, 16'h0400 + 16'(i), 0, 0, 0);
         step();
      end
      drive(0, 16'h0, 1, 0, 0);
      step();
      drive(0, 16'h0, 0, 0, 1);
      step();
      check("pre-reset busy", 32'(busy), 32'h1);
      drive(0, 16'h0, 0, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset instruction", 32'(bus.instruction), 32'h0);
      check("async reset busy", 32'(busy), 32'h0);
      check("async reset count", 32'(count), 32'h0);
`ifdef INST_QUEUE_PERF_CNT_EN
      check("async reset issued_cnt", issued_cnt, 32'h0);
`endif
      reset_n = 1'b1;
      step();
      check("post-reset count", 32'(count), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
